bnn_weight_streamer: RTL and testbench

- Host-side sequencer that drives the BNN weight-load interface (the `load_en` strobe plus a 6-bit weight word).
- Accepts weights as a bit-serial stream with a valid/ready handshake.
- Assembles each NUM_WEIGHTS-bit word MSB-first, then issues exactly one load strobe per word for NUM_NEURONS words, then reports done.
- Sits between the chip's input pins and the BNN core, replacing manual per-word strobing.

---
 rtl/bnn_weight_streamer_if.sv | 28 ++
 rtl/bnn_weight_streamer.sv | 115 +++++++++++
 tb/tb_bnn_weight_streamer.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bnn_weight_streamer_if.sv
// Bus between the host-side stimulus (master) and the weight streamer (slave).
// Serial input handshake: a bit moves on a rising edge where ser_valid and ser_ready are both 1.
interface bnn_weight_streamer_if #(
  parameter int NUM_WEIGHTS = 6,
  parameter int IDX_W       = 3
);
  logic                   start;
  logic                   abort;
  logic                   ser_data;
  logic                   ser_valid;
  logic                   ser_ready;
  logic                   load_en;
  logic [NUM_WEIGHTS-1:0] weight_out;
  logic [IDX_W-1:0]       word_idx;
  logic                   busy;
  logic                   done;
  logic [1:0]             state_dbg;

  modport master (
    output start, abort, ser_data, ser_valid,
    input  ser_ready, load_en, weight_out, word_idx, busy, done, state_dbg
  );

  modport slave (
    input  start, abort, ser_data, ser_valid,
    output ser_ready, load_en, weight_out, word_idx, busy, done, state_dbg
  );
endinterface

// File: rtl/bnn_weight_streamer.sv
// Assembles bit-serial weights MSB-first into NUM_WEIGHTS-bit words and strobes
// each one into the BNN core, NUM_NEURONS words per load sequence.
module bnn_weight_streamer #(
  parameter int NUM_NEURONS = 4,
  parameter int NUM_WEIGHTS = 6,
  parameter int IDX_W       = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  bnn_weight_streamer_if.slave   bus
);
  localparam int CNT_W = $clog2(NUM_WEIGHTS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_WEIGHTS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, EMIT = 2'd2, DONE = 2'd3} state_t;

  state_t                 state_q, state_d;
  // Only the bits already received are kept; the final bit joins them directly.
  logic [NUM_WEIGHTS-2:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_WEIGHTS-1:0] weight_q, weight_d;
  logic                   load_en_q, load_en_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   ready_q, ready_d;
  logic                   accept;

  assign accept = ready_q && bus.ser_valid;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    weight_d = weight_q;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d = SHIFT;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        // abort outranks a coinciding final bit, so that word is never strobed
        if (bus.abort) begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (accept) begin
          shreg_d = {shreg_q[NUM_WEIGHTS-3:0], bus.ser_data};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            state_d  = EMIT;
            weight_d = {shreg_q, bus.ser_data};
          end
        end
      end
      EMIT: begin
        if (bus.abort) begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
          idx_d   = idx_q + 1'b1;
          cnt_d   = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered decodes of the state being entered.
    load_en_d = (state_d == EMIT);
    busy_d    = (state_d == SHIFT) || (state_d == EMIT);
    done_d    = (state_d == DONE);
    ready_d   = (state_d == SHIFT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      weight_q  <= '0;
      load_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      weight_q  <= weight_d;
      load_en_q <= load_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.ser_ready  = ready_q;
  assign bus.load_en    = load_en_q;
  assign bus.weight_out = weight_q;
  assign bus.word_idx   = idx_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_bnn_weight_streamer.sv
// Directed bench for bnn_weight_streamer: every word fully sent is expected to be
// strobed once, in order, with its index; sequences ending in word NN-1 expect one done.
module tb_bnn_weight_streamer;
  localparam int NN = 4;
  localparam int NW = 6;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bnn_weight_streamer_if #(.NUM_WEIGHTS(NW), .IDX_W(IW)) bus ();

  bnn_weight_streamer #(.NUM_NEURONS(NN), .NUM_WEIGHTS(NW), .IDX_W(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [IW+NW-1:0] exp_q[$];
  int exp_done = 0;
  int cyc = 0;
  int t_start = 0;
  int load_t[$];
  int done_t[$];
  logic [NW-1:0] load_w[$];
  logic [IW+NW-1:0] exp_e;
  logic [NW-1:0] words[NN] = '{6'b111000, 6'b000111, 6'b001100, 6'b110011};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: every strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.load_en) begin
        load_t.push_back(cyc);
        load_w.push_back(bus.weight_out);
        if (exp_q.size() == 0) begin
          check("unexpected_load", {23'd0, bus.word_idx, bus.weight_out}, 32'h1ff);
        end else begin
          exp_e = exp_q.pop_front();
          check("load_word", {23'd0, bus.word_idx, bus.weight_out}, {23'd0, exp_e});
        end
      end
      if (bus.done) begin
        done_t.push_back(cyc);
        check("done_expected", (exp_done > 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_done > 0) exp_done--;
      end
      check("ready_implies_busy", {31'd0, bus.ser_ready & ~bus.busy}, 32'd0);
      check("done_not_busy", {31'd0, bus.done & bus.busy}, 32'd0);
    end
  end

  task automatic do_start();
    bus.start = 1'b1;
    t_start   = cyc;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Drives bits [from, to) of w MSB-first; gapped holds ser_valid low every other cycle.
  task automatic send_bits(input logic [NW-1:0] w, input int from, input int to, input bit gapped);
    int sent = from;
    int guard = 0;
    bit gap = 1'b0;
    while (sent < to && guard < 100) begin
      if (gapped && gap) begin
        bus.ser_valid = 1'b0;
      end else if (bus.ser_ready) begin
        bus.ser_valid = 1'b1;
        bus.ser_data  = w[NW-1-sent];
        sent++;
      end else begin
        bus.ser_valid = 1'b0;
      end
      gap = ~gap;
      guard++;
      @(negedge clk);
    end
    bus.ser_valid = 1'b0;
    if (sent < to) check("send_timeout", 32'(sent), 32'(to));
  endtask

  task automatic send_word(input logic [NW-1:0] w, input int idx, input bit gapped);
    exp_q.push_back({IW'(idx), w});
    if (idx == NN - 1) exp_done++;
    send_bits(w, 0, NW, gapped);
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q.size() != 0 || exp_done != 0) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("drain", 32'(exp_q.size() + exp_done), 32'd0);
  endtask

  task automatic run_seq(input bit gapped);
    do_start();
    for (int i = 0; i < NN; i++) send_word(words[i], i, gapped);
    drain();
  endtask

  task automatic clear_logs();
    load_t.delete();
    done_t.delete();
    load_w.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.ser_data = 1'b0;
    bus.ser_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, bus.ser_ready}, 32'd0);
    check("rst_load", {31'd0, bus.load_en}, 32'd0);
    check("rst_weight", {26'd0, bus.weight_out}, 32'd0);
    check("rst_idx", {29'd0, bus.word_idx}, 32'd0);
    check("rst_busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Nominal load with literal timing and word pins
    clear_logs();
    run_seq(1'b0);
    check("nom_n_loads", 32'(load_t.size()), 32'd4);
    check("nom_n_done", 32'(done_t.size()), 32'd1);
    if (load_t.size() == 4 && done_t.size() == 1) begin
      for (int k = 0; k < 4; k++) check("nom_load_cycle", 32'(load_t[k] - t_start), 32'(7 * (k + 1)));
      check("nom_done_cycle", 32'(done_t[0] - t_start), 32'd29);
      check("nom_word0_lit", {26'd0, load_w[0]}, 32'b111000);
      check("nom_word3_lit", {26'd0, load_w[3]}, 32'b110011);
    end
    repeat (2) @(negedge clk);
    check("nom_after_busy", {31'd0, bus.busy}, 32'd0);
    check("nom_after_idx", {29'd0, bus.word_idx}, 32'd3);

    // Gapped valid
    clear_logs();
    run_seq(1'b1);
    check("gap_n_loads", 32'(load_t.size()), 32'd4);
    check("gap_n_done", 32'(done_t.size()), 32'd1);
    repeat (2) @(negedge clk);

    // Abort mid-word 1, then a clean sequence from index 0
    clear_logs();
    do_start();
    send_word(words[0], 0, 1'b0);
    send_bits(words[1], 0, 3, 1'b0);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_ready", {31'd0, bus.ser_ready}, 32'd0);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_idx", {29'd0, bus.word_idx}, 32'd0);
    repeat (10) @(negedge clk);
    check("abort_n_loads", 32'(load_t.size()), 32'd1);
    check("abort_n_done", 32'(done_t.size()), 32'd0);
    clear_logs();
    run_seq(1'b0);
    check("rerun_n_loads", 32'(load_t.size()), 32'd4);
    repeat (2) @(negedge clk);

    // Abort coinciding with the final bit of word 2
    clear_logs();
    do_start();
    send_word(words[0], 0, 1'b0);
    send_word(words[1], 1, 1'b0);
    send_bits(words[2], 0, NW - 1, 1'b0);
    check("emit_abort_ready", {31'd0, bus.ser_ready}, 32'd1);
    bus.ser_valid = 1'b1;
    bus.ser_data  = words[2][0];
    bus.abort     = 1'b1;
    @(negedge clk);
    bus.ser_valid = 1'b0;
    bus.abort     = 1'b0;
    check("emit_abort_load", {31'd0, bus.load_en}, 32'd0);
    check("emit_abort_idle", {30'd0, bus.state_dbg}, 32'd0);
    repeat (10) @(negedge clk);
    check("emit_abort_n_loads", 32'(load_t.size()), 32'd2);
    check("emit_abort_n_done", 32'(done_t.size()), 32'd0);

    // Asynchronous reset during word 3
    clear_logs();
    do_start();
    for (int i = 0; i < 3; i++) send_word(words[i], i, 1'b0);
    send_bits(words[3], 0, 2, 1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_ready", {31'd0, bus.ser_ready}, 32'd0);
    check("arst_load", {31'd0, bus.load_en}, 32'd0);
    check("arst_weight", {26'd0, bus.weight_out}, 32'd0);
    check("arst_idx", {29'd0, bus.word_idx}, 32'd0);
    check("arst_busy_done", {30'd0, bus.busy, bus.done}, 32'd0);
    check("arst_state", {30'd0, bus.state_dbg}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.ser_valid = 1'b1;
      bus.ser_data  = i[0];
      @(negedge clk);
      check("post_rst_ready", {31'd0, bus.ser_ready}, 32'd0);
    end
    bus.ser_valid = 1'b0;
    check("post_rst_n_loads", 32'(load_t.size()), 32'd3);
    check("post_rst_queue", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // Spurious start pulses during SHIFT and DONE
    clear_logs();
    do_start();
    send_word(words[0], 0, 1'b0);
    exp_q.push_back({IW'(1), words[1]});
    send_bits(words[1], 0, 2, 1'b0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    send_bits(words[1], 2, NW, 1'b0);
    send_word(words[2], 2, 1'b0);
    send_word(words[3], 3, 1'b0);
    @(negedge clk);
    check("spur_in_done", {31'd0, bus.done}, 32'd1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("spur_idle", {30'd0, bus.state_dbg}, 32'd0);
    repeat (5) @(negedge clk);
    drain();
    check("spur_busy", {31'd0, bus.busy}, 32'd0);
    check("spur_n_loads", 32'(load_t.size()), 32'd4);
    check("spur_n_done", 32'(done_t.size()), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
